// File: rtl/control_fsm_if.sv
// control_fsm_if: groups the instruction/flag inputs and datapath control outputs of the
// multi-cycle control FSM.
//   opcode/m      : instruction[15:12] and mode bit, sampled by the FSM in FETCH
//   z/n           : registered zero/negative ALU flags
//   AluSrc..ST    : single-bit datapath controls
//   AluOp/PcSrc/instType : 2-bit datapath selects
//   state         : current FSM state (debug)
//   inst_done     : pulse in the final cycle of each instruction
// master = datapath side (drives opcode/m/z/n), slave = control FSM.
interface control_fsm_if;
    logic [3:0] opcode;
    logic       m;
    logic       z;
    logic       n;

    logic       AluSrc;
    logic       MemR;
    logic       MemW;
    logic       RegWr;
    logic       RegDes;
    logic       WrB;
    logic       ExtOp;
    logic       R0;
    logic       R7;
    logic       load;
    logic       ByteOrWord;
    logic       ST;
    logic [1:0] AluOp;
    logic [1:0] PcSrc;
    logic [1:0] instType;
    logic [2:0] state;
    logic       inst_done;

    modport master (
        output opcode, m, z, n,
        input  AluSrc, MemR, MemW, RegWr, RegDes, WrB, ExtOp, R0, R7, load, ByteOrWord, ST,
        input  AluOp, PcSrc, instType, state, inst_done
    );

    modport slave (
        input  opcode, m, z, n,
        output AluSrc, MemR, MemW, RegWr, RegDes, WrB, ExtOp, R0, R7, load, ByteOrWord, ST,
        output AluOp, PcSrc, instType, state, inst_done
    );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle Moore control unit for a 16-bit processor.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : control_fsm_if.slave -- opcode/m/z/n in, datapath controls/selects,
//           debug state and inst_done out
// Path per instruction class:
//   JMP/CALL/RET : FETCH -> DECODE
//   ALU          : FETCH -> DECODE -> EXEC -> WB
//   branches     : FETCH -> DECODE -> EXEC -> BRANCH
//   SW/SV        : FETCH -> DECODE -> EXEC -> MEM
//   LW/LB        : FETCH -> DECODE -> EXEC -> MEM -> WB
// opcode and m are captured on the FETCH->DECODE edge; everything afterwards decodes the
// captured copy so that a changing instruction bus cannot disturb an instruction in flight.
module control_fsm (
    input  logic         clk,
    input  logic         reset,
    control_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StBranch = 3'd5
    } state_e;

    localparam logic [3:0] OpAnd  = 4'h0;
    localparam logic [3:0] OpAdd  = 4'h1;
    localparam logic [3:0] OpSub  = 4'h2;
    localparam logic [3:0] OpAddi = 4'h3;
    localparam logic [3:0] OpAndi = 4'h4;
    localparam logic [3:0] OpLw   = 4'h5;
    localparam logic [3:0] OpLb   = 4'h6;
    localparam logic [3:0] OpSw   = 4'h7;
    localparam logic [3:0] OpBgt  = 4'h8;
    localparam logic [3:0] OpBlt  = 4'h9;
    localparam logic [3:0] OpBeq  = 4'hA;
    localparam logic [3:0] OpBne  = 4'hB;
    localparam logic [3:0] OpJmp  = 4'hC;
    localparam logic [3:0] OpCall = 4'hD;
    localparam logic [3:0] OpRet  = 4'hE;
    localparam logic [3:0] OpSv   = 4'hF;

    localparam logic [1:0] AluAnd = 2'b00;
    localparam logic [1:0] AluAdd = 2'b01;
    localparam logic [1:0] AluSub = 2'b10;

    localparam logic [1:0] TypeR = 2'b00;
    localparam logic [1:0] TypeI = 2'b01;
    localparam logic [1:0] TypeJ = 2'b10;
    localparam logic [1:0] TypeS = 2'b11;

    localparam logic [1:0] PcJump   = 2'b01;
    localparam logic [1:0] PcBranch = 2'b10;
    localparam logic [1:0] PcRet    = 2'b11;

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       m_q, m_d;

    // Class decode of the captured opcode
    logic       is_jump;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       uses_imm;
    logic [1:0] inst_type;
    logic [1:0] alu_op;
    logic       br_taken;

    always_comb begin
        is_jump   = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        uses_imm  = 1'b0;
        inst_type = TypeR;
        alu_op    = AluAdd;
        unique case (op_q)
            OpAnd: begin
                alu_op = AluAnd;
            end
            OpAdd: begin
                alu_op = AluAdd;
            end
            OpSub: begin
                alu_op = AluSub;
            end
            OpAddi: begin
                inst_type = TypeI;
                uses_imm  = 1'b1;
            end
            OpAndi: begin
                inst_type = TypeI;
                uses_imm  = 1'b1;
                alu_op    = AluAnd;
            end
            OpLw, OpLb: begin
                inst_type = TypeI;
                uses_imm  = 1'b1;
                is_load   = 1'b1;
            end
            OpSw: begin
                inst_type = TypeI;
                uses_imm  = 1'b1;
                is_store  = 1'b1;
            end
            OpBgt, OpBlt, OpBeq, OpBne: begin
                inst_type = TypeI;
                is_branch = 1'b1;
                alu_op    = AluSub;
            end
            OpJmp, OpCall, OpRet: begin
                inst_type = TypeJ;
                is_jump   = 1'b1;
            end
            OpSv: begin
                inst_type = TypeS;
                uses_imm  = 1'b1;
                is_store  = 1'b1;
            end
            default: begin
                inst_type = TypeR;
            end
        endcase
    end

    // Branch condition uses the live flags, so load in BRANCH is the one Mealy output.
    always_comb begin
        br_taken = 1'b0;
        case (op_q)
            OpBgt:   br_taken = !bus.z && !bus.n;
            OpBlt:   br_taken = bus.n;
            OpBeq:   br_taken = bus.z;
            OpBne:   br_taken = !bus.z;
            default: br_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            op_q    <= 4'h0;
            m_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            m_q     <= m_d;
        end
    end

    logic       alu_src_o;
    logic       mem_r_o;
    logic       mem_w_o;
    logic       reg_wr_o;
    logic       reg_des_o;
    logic       wr_b_o;
    logic       ext_op_o;
    logic       r7_o;
    logic       load_o;
    logic       byte_or_word_o;
    logic       st_o;
    logic [1:0] alu_op_o;
    logic [1:0] pc_src_o;
    logic [1:0] inst_type_o;
    logic       inst_done_o;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        m_d            = m_q;
        alu_src_o      = 1'b0;
        mem_r_o        = 1'b0;
        mem_w_o        = 1'b0;
        reg_wr_o       = 1'b0;
        reg_des_o      = 1'b0;
        wr_b_o         = 1'b0;
        ext_op_o       = 1'b0;
        r7_o           = 1'b0;
        load_o         = 1'b0;
        byte_or_word_o = 1'b0;
        st_o           = 1'b0;
        alu_op_o       = 2'b00;
        pc_src_o       = 2'b00;
        inst_type_o    = 2'b00;
        inst_done_o    = 1'b0;

        case (state_q)
            StFetch: begin
                op_d    = bus.opcode;
                m_d     = bus.m;
                state_d = StDecode;
            end
            StDecode: begin
                inst_type_o = inst_type;
                if (is_jump) begin
                    load_o      = 1'b1;
                    pc_src_o    = (op_q == OpRet) ? PcRet : PcJump;
                    r7_o        = (op_q == OpCall);
                    reg_wr_o    = (op_q == OpCall);
                    inst_done_o = 1'b1;
                    state_d     = StFetch;
                end else begin
                    // Stores and branches read rd as a source operand
                    reg_des_o = is_store || is_branch;
                    state_d   = StExec;
                end
            end
            StExec: begin
                inst_type_o = inst_type;
                alu_op_o    = alu_op;
                alu_src_o   = uses_imm;
                ext_op_o    = (op_q != OpAndi);
                if (is_load || is_store) begin
                    state_d = StMem;
                end else if (is_branch) begin
                    state_d = StBranch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                inst_type_o = inst_type;
                if (is_load) begin
                    mem_r_o = 1'b1;
                    state_d = StWb;
                end else begin
                    mem_w_o     = 1'b1;
                    st_o        = (op_q == OpSw);
                    inst_done_o = 1'b1;
                    state_d     = StFetch;
                end
            end
            StWb: begin
                inst_type_o    = inst_type;
                reg_wr_o       = 1'b1;
                wr_b_o         = is_load;
                byte_or_word_o = is_load && m_q;
                inst_done_o    = 1'b1;
                state_d        = StFetch;
            end
            StBranch: begin
                inst_type_o = inst_type;
                pc_src_o    = PcBranch;
                load_o      = br_taken;
                inst_done_o = 1'b1;
                state_d     = StFetch;
            end
            default: begin
                // Unused codes 6/7: outputs stay at their zero defaults
                state_d = StFetch;
            end
        endcase
    end

    assign bus.AluSrc     = alu_src_o;
    assign bus.MemR       = mem_r_o;
    assign bus.MemW       = mem_w_o;
    assign bus.RegWr      = reg_wr_o;
    assign bus.RegDes     = reg_des_o;
    assign bus.WrB        = wr_b_o;
    assign bus.ExtOp      = ext_op_o;
    assign bus.R0         = 1'b0;
    assign bus.R7         = r7_o;
    assign bus.load       = load_o;
    assign bus.ByteOrWord = byte_or_word_o;
    assign bus.ST         = st_o;
    assign bus.AluOp      = alu_op_o;
    assign bus.PcSrc      = pc_src_o;
    assign bus.instType   = inst_type_o;
    assign bus.state      = state_q;
    assign bus.inst_done  = inst_done_o;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: directed plus randomized checks of control_fsm against a per-instruction
// trace model. Each instruction is turned into the list of cycles it should occupy, with the
// full control word expected in each cycle; the opcode/m bus is scrambled after FETCH.
module tb_control_fsm;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    control_fsm_if u_if ();

    control_fsm u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    typedef struct packed {
        logic [2:0] fsm;
        logic       done;
        logic       alusrc;
        logic       memr;
        logic       memw;
        logic       regwr;
        logic       regdes;
        logic       wrb;
        logic       extop;
        logic       r0;
        logic       r7;
        logic       load;
        logic       bow;
        logic       st;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic [1:0] itype;
    } ctl_t;

    int unsigned tests = 0;
    int unsigned fails = 0;
    ctl_t        exp_q[$];

    function automatic ctl_t observe();
        ctl_t c;
        c.fsm    = u_if.state;
        c.done   = u_if.inst_done;
        c.alusrc = u_if.AluSrc;
        c.memr   = u_if.MemR;
        c.memw   = u_if.MemW;
        c.regwr  = u_if.RegWr;
        c.regdes = u_if.RegDes;
        c.wrb    = u_if.WrB;
        c.extop  = u_if.ExtOp;
        c.r0     = u_if.R0;
        c.r7     = u_if.R7;
        c.load   = u_if.load;
        c.bow    = u_if.ByteOrWord;
        c.st     = u_if.ST;
        c.aluop  = u_if.AluOp;
        c.pcsrc  = u_if.PcSrc;
        c.itype  = u_if.instType;
        return c;
    endfunction

    task automatic check(input string tag, input ctl_t obs, input ctl_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Expected cycle-by-cycle control words for one instruction.
    task automatic build_trace(input logic [3:0] op, input logic mm, input logic zz,
                               input logic nn);
        ctl_t       c;
        logic [1:0] it;
        bit         jump, ld, sto, br;
        exp_q.delete();
        jump = (op >= 4'd12 && op <= 4'd14);
        ld   = (op == 4'd5 || op == 4'd6);
        sto  = (op == 4'd7 || op == 4'd15);
        br   = (op >= 4'd8 && op <= 4'd11);
        if (op <= 4'd2)      it = 2'b00;
        else if (op <= 4'd11) it = 2'b01;
        else if (op <= 4'd14) it = 2'b10;
        else                 it = 2'b11;

        // FETCH: nothing asserted
        c = '0;
        exp_q.push_back(c);

        // DECODE
        c = '0;
        c.fsm   = 3'd1;
        c.itype = it;
        if (jump) begin
            c.load  = 1'b1;
            c.pcsrc = (op == 4'd14) ? 2'b11 : 2'b01;
            c.r7    = (op == 4'd13);
            c.regwr = (op == 4'd13);
            c.done  = 1'b1;
            exp_q.push_back(c);
            return;
        end
        c.regdes = sto || br;
        exp_q.push_back(c);

        // EXEC
        c = '0;
        c.fsm    = 3'd2;
        c.itype  = it;
        c.aluop  = (op == 4'd0 || op == 4'd4) ? 2'b00 :
                   (op == 4'd2 || br)         ? 2'b10 : 2'b01;
        c.alusrc = (op >= 4'd3 && op <= 4'd7) || op == 4'd15;
        c.extop  = (op != 4'd4);
        exp_q.push_back(c);

        if (br) begin
            c = '0;
            c.fsm   = 3'd5;
            c.itype = it;
            c.pcsrc = 2'b10;
            case (op)
                4'd8:    c.load = !zz && !nn;
                4'd9:    c.load = nn;
                4'd10:   c.load = zz;
                default: c.load = !zz;
            endcase
            c.done = 1'b1;
            exp_q.push_back(c);
            return;
        end

        if (ld || sto) begin
            c = '0;
            c.fsm   = 3'd3;
            c.itype = it;
            c.memr  = ld;
            c.memw  = sto;
            c.st    = (op == 4'd7);
            c.done  = sto;
            exp_q.push_back(c);
            if (sto) return;
        end

        // WB
        c = '0;
        c.fsm   = 3'd4;
        c.itype = it;
        c.regwr = 1'b1;
        c.wrb   = ld;
        c.bow   = ld && mm;
        c.done  = 1'b1;
        exp_q.push_back(c);
    endtask

    // Runs up to 'limit' cycles of an instruction (0 = whole trace); starts and ends on a
    // falling edge. The opcode/m bus is randomized after the FETCH cycle.
    task automatic run_instr(input logic [3:0] op, input logic mm, input logic zz,
                             input logic nn, input int limit);
        int ncyc;
        build_trace(op, mm, zz, nn);
        ncyc = (limit == 0) ? exp_q.size() : limit;
        for (int i = 0; i < ncyc; i++) begin
            if (i == 0) begin
                u_if.opcode = op;
                u_if.m      = mm;
            end else begin
                u_if.opcode = 4'($urandom);
                u_if.m      = 1'($urandom);
            end
            u_if.z = zz;
            u_if.n = nn;
            #1;
            check($sformatf("op%0h_m%0d_z%0d_n%0d_cyc%0d", op, mm, zz, nn, i), observe(),
                  exp_q[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        ctl_t zero_c;
        zero_c = '0;
        reset       = 1'b0;
        u_if.opcode = 4'h1;
        u_if.m      = 1'b1;
        u_if.z      = 1'b1;
        u_if.n      = 1'b1;

        // Reset holds everything at zero across clock edges
        repeat (2) @(negedge clk);
        #1 check("reset_hold", observe(), zero_c);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_instr(4'h1, 1'b0, 1'b0, 1'b0, 0);  // ADD
        run_instr(4'h6, 1'b1, 1'b0, 1'b0, 0);  // LB, byte mode
        run_instr(4'hA, 1'b0, 1'b1, 1'b0, 0);  // BEQ taken
        run_instr(4'hA, 1'b0, 1'b0, 1'b1, 0);  // BEQ not taken
        run_instr(4'hD, 1'b0, 1'b0, 1'b0, 0);  // CALL
        run_instr(4'hE, 1'b1, 1'b0, 1'b0, 0);  // RET
        run_instr(4'hF, 1'b0, 1'b0, 1'b0, 0);  // SV
        run_instr(4'h7, 1'b1, 1'b0, 1'b0, 0);  // SW
        run_instr(4'h4, 1'b0, 1'b0, 1'b0, 0);  // ANDI
        run_instr(4'h8, 1'b0, 1'b0, 1'b0, 0);  // BGT taken
        run_instr(4'h9, 1'b0, 1'b0, 1'b0, 0);  // BLT not taken

        // Abort a LW in MEM with an asynchronous reset pulse
        run_instr(4'h5, 1'b0, 1'b0, 1'b0, 3);
        #1 check("lw_mem_before_abort", observe(), exp_q[3]);
        #2 reset = 1'b0;
        #1 check("abort_immediate", observe(), zero_c);
        @(posedge clk);
        #1 check("abort_held_over_edge", observe(), zero_c);
        @(negedge clk);
        reset = 1'b1;
        run_instr(4'hC, 1'b0, 1'b0, 1'b0, 0);  // JMP right after release
        run_instr(4'h5, 1'b0, 1'b0, 1'b0, 0);  // full LW

        // Randomized instruction stream
        for (int k = 0; k < 80; k++) begin
            run_instr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 4 bits: instruction[15:12] from the fetched instruction.
REQ-004 SHALL have port m, input, 1 bit: mode bit from the instruction buffer.
REQ-005 SHALL have ports z and n, inputs, 1 bit each: registered zero and negative ALU flags from the datapath.
REQ-006 SHALL have outputs AluSrc, MemR, MemW, RegWr, RegDes, WrB, ExtOp, R0, R7, load, ByteOrWord and ST, 1 bit each: datapath controls.
REQ-007 SHALL have outputs AluOp, PcSrc and instType, 2 bits each: datapath selects.
REQ-008 SHALL have output state, 3 bits: current state, for debug.
REQ-009 SHALL have output inst_done, 1 bit: one-cycle pulse in the final cycle of each instruction.

Function
REQ-010 SHALL encode states as FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, BRANCH=5; codes 6 and 7 SHALL go to FETCH on the next edge with all outputs 0.
REQ-011 SHALL latch opcode and m into internal registers on the FETCH->DECODE edge; all later states SHALL use the latched copies.
REQ-012 SHALL decode opcodes as follows:
- 0000 AND, 0001 ADD, 0010 SUB: R-type.
- 0011 ADDI, 0100 ANDI: I-type.
- 0101 LW, 0110 LB: I-type; m selects byte.
- 0111 SW: I-type.
- 1000 BGT, 1001 BLT, 1010 BEQ, 1011 BNE: I-type.
- 1100 JMP, 1101 CALL: J-type.
- 1110 RET.
- 1111 SV: S-type.
REQ-013 SHALL drive instType 00=R, 01=I, 10=J, 11=S from the latched opcode in every non-FETCH state.
REQ-014 SHALL drive AluOp 00=AND, 01=ADD, 10=SUB; LW, LB, SW, SV and ADDI SHALL use ADD; branches SHALL use SUB.
REQ-015 SHALL hold every output not explicitly listed for the current state at 0.
REQ-016 SHALL always go FETCH->DECODE.
REQ-017 SHALL complete JMP, CALL and RET in DECODE, returning to FETCH, with:
- load=1.
- PcSrc=01 for JMP and CALL, 11 for RET.
- CALL additionally R7=1 and RegWr=1.
REQ-018 SHALL go DECODE->EXEC for all other opcodes, with RegDes=1 for SW, SV and branches.
REQ-019 SHALL drive AluSrc=1 in EXEC for all I-type and S-type ALU uses, and 0 for R-type and branches.
REQ-020 SHALL drive ExtOp=1 (sign extension) except for ANDI, where ExtOp=0 (zero extension).
REQ-021 SHALL route EXEC->MEM for LW, LB, SW and SV; EXEC->BRANCH for branches; EXEC->WB otherwise.
REQ-022 SHALL behave in MEM as follows:
- LW and LB: MemR=1, then go to WB.
- SW: MemW=1, ST=1, then go to FETCH.
- SV: MemW=1, ST=0, then go to FETCH.
REQ-023 SHALL drive RegWr=1 in WB, with WrB=1 and ByteOrWord=latched m for LW/LB and WrB=0 otherwise, then go to FETCH.
REQ-024 SHALL drive PcSrc=10 in BRANCH, then go to FETCH, with load=1 when taken:
- BGT taken when !z & !n.
- BLT taken when n.
- BEQ taken when z.
- BNE taken when !z.
REQ-025 SHALL assert inst_done in the last state of every path: DECODE for JMP/CALL/RET, MEM for stores, WB, or BRANCH.
REQ-026 SHALL never assert load with MemW, and never assert MemR with MemW, in the same cycle.
REQ-027 SHALL derive outputs combinationally from state and the latched opcode only (Moore), except load in BRANCH, which also depends on z and n.
REQ-028 SHALL give the following cycle counts:
- JMP, CALL, RET: 2.
- ALU instructions: 4.
- Branches: 4.
- SW, SV: 4.
- LW, LB: 5.

Reset
REQ-029 SHALL, while reset=0, force state=FETCH, clear the latched opcode and m to 0, and drive all outputs to 0, independent of clk.
REQ-030 SHALL abort any instruction in progress when reset is asserted; on release, the first rising edge SHALL go FETCH->DECODE.

Verification
REQ-031 SHALL cover: reset pulse during MEM of a LW -> state=0, MemR=0 immediately; the next instruction starts cleanly.
REQ-032 SHALL cover: opcode=0001 (ADD) -> states 0,1,2,4,0; RegWr=1 only in WB; AluOp=01, AluSrc=0 in EXEC; inst_done once.
REQ-033 SHALL cover: opcode=0110 with m=1 -> states 0,1,2,3,4; MemR=1 in MEM; WB has WrB=1, ByteOrWord=1.
REQ-034 SHALL cover BEQ twice:
- z=1 -> BRANCH has load=1, PcSrc=10.
- z=0 -> load=0.
REQ-035 SHALL cover: opcode=1101 (CALL) -> DECODE has load=1, PcSrc=01, R7=1, RegWr=1; state is 0 on the next edge.
REQ-036 SHALL cover: opcode changes mid-instruction (after FETCH) -> outputs follow the latched opcode, unaffected.
